// File: rtl/ntt_bank_ctrl_pkg.sv
// Shared constants and state encoding for the banked NTT/INTT controller.
package ntt_ctrl_pkg;

  localparam int N         = 256;
  localparam int LOGN      = 8;
  localparam int NUM_BANKS = 4;

  // Butterfly roles; the value doubles as the network select code.
  localparam logic [1:0] ROLE_U0 = 2'b00;
  localparam logic [1:0] ROLE_V0 = 2'b01;
  localparam logic [1:0] ROLE_U1 = 2'b10;
  localparam logic [1:0] ROLE_V1 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/ntt_bank_ctrl_if.sv
// Command and banked-memory bus of the NTT controller.
// master: command/datapath side; slave: the controller itself.
interface ntt_bank_ctrl_if #(
  parameter int ADDR_W = 6
);

  logic              start;
  logic              mode;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3;
  logic [1:0]        sel_a_0, sel_a_1, sel_a_2, sel_a_3;
  logic [7:0]        zeta_idx_0, zeta_idx_1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3;
  logic [1:0]        sel_b_0, sel_b_1, sel_b_2, sel_b_3;

  modport master (
    output start, mode,
    input  busy, done, rd_en, rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
           sel_a_0, sel_a_1, sel_a_2, sel_a_3, zeta_idx_0, zeta_idx_1,
           wr_en, wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3,
           sel_b_0, sel_b_1, sel_b_2, sel_b_3
  );

  modport slave (
    input  start, mode,
    output busy, done, rd_en, rd_addr_0, rd_addr_1, rd_addr_2, rd_addr_3,
           sel_a_0, sel_a_1, sel_a_2, sel_a_3, zeta_idx_0, zeta_idx_1,
           wr_en, wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3,
           sel_b_0, sel_b_1, sel_b_2, sel_b_3
  );

endinterface

// File: rtl/ntt_bank_ctrl_idx_map.sv
// Coefficient index to {bank, address}: bank is the base-4 digit sum
// mod 4, so the four roles of one butterfly pair never collide.
module ntt_idx_map (
  input  logic [7:0] idx,
  output logic [1:0] bank,
  output logic [5:0] addr
);

  assign bank = idx[7:6] + idx[5:4] + idx[3:2] + idx[1:0];
  assign addr = idx[7:2];

endmodule

// File: rtl/ntt_bank_ctrl.sv
// Sequencer for one 256-point Dilithium NTT/INTT over 4 RAM banks and
// 2 butterflies. Reads are issued combinationally from the stage/column
// counters; writes replay the reads through a PIPE_LAT-deep delay line.
// Build option: define NTT_CTRL_INTT_EN to honour mode (INTT); otherwise
// mode is ignored and only the NTT index/twiddle logic exists.
module ntt_bank_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = 8,
  parameter int ADDR_W   = 6
) (
  input logic            clk,
  input logic            rst,
  ntt_bank_ctrl_if.slave bus
);

  localparam int DL_W = 1 + NUM_BANKS * ADDR_W + NUM_BANKS * 2;

  state_t            state_r, state_s;
  logic [2:0]        stage_r, stage_s;
  logic [5:0]        c_r, c_s;
  logic [4:0]        drain_r, drain_s;
  logic              mode_r, mode_s, start_mode_s;
  logic              rd_en_s;
  logic [2:0]        p_s;
  logic [1:0]        d_s;
  logic [7:0]        h_s, h2_s, mask_s, c8_s, b_s;
  logic [7:0]        idx_s   [NUM_BANKS];
  logic [1:0]        bank_s  [NUM_BANKS];
  logic [5:0]        addr_s  [NUM_BANKS];
  logic [ADDR_W-1:0] rd_addr_a [NUM_BANKS];
  logic [1:0]        sel_a_a [NUM_BANKS];
  logic [7:0]        u_s [2];
  logic [7:0]        g_s [2];
  logic [7:0]        zeta_s [2];
  logic [DL_W-1:0]   rd_vec_s, wr_vec_s;
  logic [DL_W-1:0]   dl_r [PIPE_LAT];

`ifdef NTT_CTRL_INTT_EN
  assign start_mode_s = bus.mode;
`else
  logic unused_mode_s;
  assign unused_mode_s = bus.mode;
  assign start_mode_s  = 1'b0;
`endif

  // State, counters and latched mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      stage_r <= 3'd0;
      c_r     <= 6'd0;
      drain_r <= 5'd0;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      stage_r <= stage_s;
      c_r     <= c_s;
      drain_r <= drain_s;
      mode_r  <= mode_s;
    end
  end

  // Next state: 64 read cycles then PIPE_LAT drain cycles, eight stages.
  always_comb begin
    state_s = state_r;
    stage_s = stage_r;
    c_s     = c_r;
    drain_s = drain_r;
    mode_s  = mode_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = RUN;
          stage_s = 3'd0;
          c_s     = 6'd0;
          mode_s  = start_mode_s;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (c_r == 6'd63) begin
          state_s = DRAIN;
          c_s     = 6'd0;
          drain_s = 5'd0;
        end else begin
          c_s = c_r + 6'd1;
        end
      end
      DRAIN: begin
        if (drain_r == 5'(PIPE_LAT - 1)) begin
          if (stage_r == 3'd7) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
            stage_s = stage_r + 3'd1;
          end
        end else begin
          drain_s = drain_r + 5'd1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign rd_en_s  = (state_r == RUN);
  assign bus.busy = (state_r == RUN) || (state_r == DRAIN);
  assign bus.done = (state_r == DONE);

  // Butterfly indices: base b is c with two zero bits spliced in at 2d.
  always_comb begin
`ifdef NTT_CTRL_INTT_EN
    if (mode_r) begin
      p_s = stage_r;
    end else begin
      p_s = 3'd7 - stage_r;
    end
`else
    p_s = 3'd7 - stage_r;
`endif
    h_s = 8'd1 << p_s;
    if (p_s[0]) begin
      h2_s = h_s >> 1;
    end else begin
      h2_s = h_s << 1;
    end
    d_s    = p_s[2:1];
    mask_s = (8'd1 << {d_s, 1'b0}) - 8'd1;
    c8_s   = {2'b00, c_r};
    b_s    = ((c8_s & ~mask_s) << 2) | (c8_s & mask_s);
    idx_s[ROLE_U0] = b_s;
    idx_s[ROLE_V0] = b_s + h_s;
    idx_s[ROLE_U1] = b_s + h2_s;
    idx_s[ROLE_V1] = b_s + h_s + h2_s;
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_map
    ntt_idx_map u_map (
      .idx  (idx_s[gi]),
      .bank (bank_s[gi]),
      .addr (addr_s[gi])
    );
  end

  // Twiddle index per butterfly from its u index.
  always_comb begin
    u_s[0] = b_s;
    u_s[1] = b_s + h2_s;
    for (int j = 0; j < 2; j++) begin
      g_s[j] = u_s[j] >> ({1'b0, p_s} + 4'd1);
`ifdef NTT_CTRL_INTT_EN
      if (mode_r) begin
        zeta_s[j] = (8'hFF >> p_s) - g_s[j];
      end else begin
        zeta_s[j] = (8'h80 >> p_s) + g_s[j];
      end
`else
      zeta_s[j] = (8'h80 >> p_s) + g_s[j];
`endif
    end
  end

  // Route each role's address and role code to the bank that holds it.
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      rd_addr_a[k] = {ADDR_W{1'b0}};
      sel_a_a[k]   = 2'b00;
    end
    if (rd_en_s) begin
      for (int r = 0; r < NUM_BANKS; r++) begin
        rd_addr_a[bank_s[r]] = addr_s[r];
        sel_a_a[bank_s[r]]   = 2'(r);
      end
    end else begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        rd_addr_a[k] = {ADDR_W{1'b0}};
        sel_a_a[k]   = 2'b00;
      end
    end
  end

  assign rd_vec_s = {rd_en_s, rd_addr_a[3], rd_addr_a[2], rd_addr_a[1], rd_addr_a[0],
                     sel_a_a[3], sel_a_a[2], sel_a_a[1], sel_a_a[0]};

  // Write-side delay line; reset discards any writes still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_r[i] <= {DL_W{1'b0}};
      end
    end else begin
      dl_r[0] <= rd_vec_s;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_r[i] <= dl_r[i-1];
      end
    end
  end

  assign wr_vec_s = dl_r[PIPE_LAT-1];

  assign bus.rd_en      = rd_en_s;
  assign bus.rd_addr_0  = rd_addr_a[0];
  assign bus.rd_addr_1  = rd_addr_a[1];
  assign bus.rd_addr_2  = rd_addr_a[2];
  assign bus.rd_addr_3  = rd_addr_a[3];
  assign bus.sel_a_0    = sel_a_a[0];
  assign bus.sel_a_1    = sel_a_a[1];
  assign bus.sel_a_2    = sel_a_a[2];
  assign bus.sel_a_3    = sel_a_a[3];
  assign bus.zeta_idx_0 = rd_en_s ? zeta_s[0] : 8'd0;
  assign bus.zeta_idx_1 = rd_en_s ? zeta_s[1] : 8'd0;

  assign bus.wr_en     = wr_vec_s[DL_W-1];
  assign bus.wr_addr_0 = wr_vec_s[8 + 0*ADDR_W +: ADDR_W];
  assign bus.wr_addr_1 = wr_vec_s[8 + 1*ADDR_W +: ADDR_W];
  assign bus.wr_addr_2 = wr_vec_s[8 + 2*ADDR_W +: ADDR_W];
  assign bus.wr_addr_3 = wr_vec_s[8 + 3*ADDR_W +: ADDR_W];
  assign bus.sel_b_0   = wr_vec_s[1:0];
  assign bus.sel_b_1   = wr_vec_s[3:2];
  assign bus.sel_b_2   = wr_vec_s[5:4];
  assign bus.sel_b_3   = wr_vec_s[7:6];

endmodule
